fir_coef_sequencer: RTL and testbench

FIR_COEF_SEQUENCER -- requirements
Module: fir_coef_sequencer

---
 rtl/fir_coef_sequencer.sv | 139 +++++++++++++
 tb/tb_fir_coef_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_coef_sequencer.sv
// Sequences a tapped-delay-line FIR: forwards samples while running, streams a
// full coefficient set into the tap RAM on request, then flushes the delay line.
module fir_coef_sequencer #(
  parameter int ORDER          = 50,
  parameter int DATA_IN_WIDTH  = 16,
  parameter int TAP_DATA_WIDTH = 16,
  parameter int TAP_ADDR_WIDTH = 6
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_run,
  input  logic                      i_load_req,
  input  logic                      i_coef_valid,
  input  logic [TAP_DATA_WIDTH-1:0] i_coef_data,
  output logic                      o_coef_ready,
  input  logic                      i_smp_valid,
  input  logic [DATA_IN_WIDTH-1:0]  i_smp_data,
  output logic                      o_smp_ready,
  output logic                      o_fir_en,
  output logic [DATA_IN_WIDTH-1:0]  o_fir_data_in,
  output logic                      o_tap_wr_en,
  output logic [TAP_ADDR_WIDTH-1:0] o_tap_wr_addr,
  output logic [TAP_DATA_WIDTH-1:0] o_tap_wr_data,
  output logic                      o_out_valid,
  output logic                      o_busy
);

  localparam int FLUSH_W = $clog2(ORDER + 3);
  localparam logic [TAP_ADDR_WIDTH-1:0] TAP_LAST   = TAP_ADDR_WIDTH'(ORDER);
  localparam logic [FLUSH_W-1:0]        FLUSH_LAST = FLUSH_W'(ORDER + 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LOAD  = 2'd2,
    FLUSH = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic [TAP_ADDR_WIDTH-1:0] tapCnt_q, tapCnt_d;
  logic [FLUSH_W-1:0]        flushCnt_q, flushCnt_d;
  logic [1:0]                primeCnt_q, primeCnt_d;
  logic                      pending_q, pending_d;
  logic                      outValid_q, outValid_d;
  logic                      smpAccept;

  assign o_smp_ready   = (state_q == RUN) && i_run && !i_load_req;
  assign smpAccept     = i_smp_valid && o_smp_ready;
  assign o_coef_ready  = (state_q == LOAD);
  assign o_tap_wr_en   = i_coef_valid && o_coef_ready;
  assign o_tap_wr_addr = tapCnt_q;
  assign o_tap_wr_data = i_coef_data;
  assign o_fir_en      = smpAccept || (state_q == FLUSH);
  assign o_fir_data_in = (state_q == FLUSH) ? '0 : i_smp_data;
  assign o_busy        = (state_q == LOAD) || (state_q == FLUSH);
  assign o_out_valid   = outValid_q;

  // The filter needs three enabled edges (delay line plus two pipeline
  // registers) before its output reflects a real sample, hence saturating at 3.
  always_comb begin
    state_d    = state_q;
    tapCnt_d   = tapCnt_q;
    flushCnt_d = flushCnt_q;
    primeCnt_d = primeCnt_q;
    pending_d  = pending_q;
    outValid_d = smpAccept && (primeCnt_q >= 2'd2);
    if (smpAccept && (primeCnt_q != 2'd3)) begin
      primeCnt_d = primeCnt_q + 2'd1;
    end

    case (state_q)
      IDLE, RUN: begin
        if (i_load_req) begin
          state_d   = LOAD;
          tapCnt_d  = '0;
          pending_d = 1'b0;
        end else if (i_run) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (i_load_req) begin
          pending_d = 1'b1;
        end
        if (o_tap_wr_en) begin
          if (tapCnt_q == TAP_LAST) begin
            state_d    = FLUSH;
            flushCnt_d = '0;
          end else begin
            tapCnt_d = tapCnt_q + TAP_ADDR_WIDTH'(1);
          end
        end
      end
      FLUSH: begin
        if (i_load_req) begin
          pending_d = 1'b1;
        end
        // A request landing on the very last flush cycle still counts as pending.
        if (flushCnt_q == FLUSH_LAST) begin
          flushCnt_d = '0;
          primeCnt_d = '0;
          if (pending_q || i_load_req) begin
            state_d   = LOAD;
            tapCnt_d  = '0;
            pending_d = 1'b0;
          end else if (i_run) begin
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end else begin
          flushCnt_d = flushCnt_q + FLUSH_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      tapCnt_q   <= '0;
      flushCnt_q <= '0;
      primeCnt_q <= '0;
      pending_q  <= 1'b0;
      outValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tapCnt_q   <= tapCnt_d;
      flushCnt_q <= flushCnt_d;
      primeCnt_q <= primeCnt_d;
      pending_q  <= pending_d;
      outValid_q <= outValid_d;
    end
  end

endmodule

// File: tb/tb_fir_coef_sequencer.sv
// Directed/randomised bench for fir_coef_sequencer with a behavioural FIR sink
// and an accepted-sample count model deciding when output is valid.
module tb_fir_coef_sequencer;

  localparam int ORDER = 50;
  localparam int DW    = 16;
  localparam int TW    = 16;
  localparam int AW    = 6;

  logic          i_clk;
  logic          i_rst_n;
  logic          i_run;
  logic          i_load_req;
  logic          i_coef_valid;
  logic [TW-1:0] i_coef_data;
  logic          o_coef_ready;
  logic          i_smp_valid;
  logic [DW-1:0] i_smp_data;
  logic          o_smp_ready;
  logic          o_fir_en;
  logic [DW-1:0] o_fir_data_in;
  logic          o_tap_wr_en;
  logic [AW-1:0] o_tap_wr_addr;
  logic [TW-1:0] o_tap_wr_data;
  logic          o_out_valid;
  logic          o_busy;

  int checks   = 0;
  int passed   = 0;
  int failures = 0;

  int            primeModel    = 0;
  logic [DW-1:0] hist[$];
  bit            impulseLoaded = 0;

  longint taps[ORDER+1];
  longint dl[ORDER+1];
  longint pModel = 0;
  longint yModel = 0;

  fir_coef_sequencer #(
    .ORDER(ORDER), .DATA_IN_WIDTH(DW), .TAP_DATA_WIDTH(TW), .TAP_ADDR_WIDTH(AW)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_run(i_run), .i_load_req(i_load_req),
    .i_coef_valid(i_coef_valid), .i_coef_data(i_coef_data), .o_coef_ready(o_coef_ready),
    .i_smp_valid(i_smp_valid), .i_smp_data(i_smp_data), .o_smp_ready(o_smp_ready),
    .o_fir_en(o_fir_en), .o_fir_data_in(o_fir_data_in), .o_tap_wr_en(o_tap_wr_en),
    .o_tap_wr_addr(o_tap_wr_addr), .o_tap_wr_data(o_tap_wr_data),
    .o_out_valid(o_out_valid), .o_busy(o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Behavioural filter: delay line, product-sum register, output register.
  always @(posedge i_clk) begin
    longint s;
    s = 0;
    if (o_tap_wr_en && (o_tap_wr_addr <= AW'(ORDER)))
      taps[o_tap_wr_addr] <= longint'($signed(o_tap_wr_data));
    if (o_fir_en) begin
      for (int i = 0; i <= ORDER; i++) s += taps[i] * dl[i];
      for (int i = ORDER; i > 0; i--) dl[i] <= dl[i-1];
      dl[0]  <= longint'($signed(o_fir_data_in));
      pModel <= s;
      yModel <= pModel;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [DW-1:0] x);
    i_smp_valid = 1'b1;
    i_smp_data  = x;
    #1;
    checkOutput("smp_ready", o_smp_ready, 1);
    checkOutput("fir_en_accept", o_fir_en, 1);
    checkOutput("fir_data_pass", o_fir_data_in, x);
    tick();
    hist.push_back(x);
    if (primeModel < 3) primeModel++;
    checkOutput("out_valid", o_out_valid, (primeModel == 3));
    if ((primeModel == 3) && impulseLoaded)
      checkOutput("filter_out", yModel, longint'($signed(hist[hist.size()-3])));
  endtask

  task automatic idleSampleCycle();
    i_smp_valid = 1'b0;
    i_smp_data  = 16'($urandom);
    #1;
    checkOutput("fir_en_idle", o_fir_en, 0);
    tick();
    checkOutput("out_valid_idle", o_out_valid, 0);
  endtask

  task automatic requestLoad();
    i_load_req  = 1'b1;
    i_smp_valid = 1'b1;
    i_smp_data  = 16'($urandom);
    #1;
    checkOutput("ready_blocked_by_req", o_smp_ready, 0);
    checkOutput("fir_en_on_req", o_fir_en, 0);
    tick();
    i_load_req = 1'b0;
    checkOutput("load_coef_ready", o_coef_ready, 1);
    checkOutput("load_busy", o_busy, 1);
    checkOutput("load_out_valid", o_out_valid, 0);
    checkOutput("load_addr0", o_tap_wr_addr, 0);
  endtask

  task automatic loadCoefs(input bit impulse);
    int            gap;
    logic [TW-1:0] c;
    for (int idx = 0; idx <= ORDER; idx++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        i_coef_valid = 1'b0;
        i_run        = 1'($urandom_range(0, 1));
        i_smp_valid  = 1'b1;
        #1;
        checkOutput("gap_wr_en", o_tap_wr_en, 0);
        checkOutput("gap_fir_en", o_fir_en, 0);
        checkOutput("gap_coef_ready", o_coef_ready, 1);
        tick();
      end
      c            = impulse ? ((idx == 0) ? 16'd1 : 16'd0) : 16'($urandom);
      i_coef_valid = 1'b1;
      i_coef_data  = c;
      i_run        = 1'($urandom_range(0, 1));
      #1;
      checkOutput("wr_en", o_tap_wr_en, 1);
      checkOutput("wr_addr", o_tap_wr_addr, idx);
      checkOutput("wr_data", o_tap_wr_data, c);
      checkOutput("load_fir_en", o_fir_en, 0);
      tick();
    end
    i_coef_valid  = 1'b0;
    i_run         = 1'b1;
    i_smp_valid   = 1'b0;
    impulseLoaded = impulse;
  endtask

  task automatic flushPhase(input int pulseA, input int pulseB, input bit expectReload);
    int n;
    n = 0;
    while (o_busy && !o_coef_ready && (n < 200)) begin
      i_smp_valid = 1'b1;
      i_smp_data  = 16'($urandom) | 16'h0001;
      i_load_req  = (n == pulseA) || (n == pulseB);
      #1;
      checkOutput("flush_fir_en", o_fir_en, 1);
      checkOutput("flush_data_zero", o_fir_data_in, 0);
      checkOutput("flush_smp_ready", o_smp_ready, 0);
      checkOutput("flush_out_valid", o_out_valid, 0);
      tick();
      i_load_req = 1'b0;
      n++;
    end
    i_smp_valid = 1'b0;
    checkOutput("flush_length", n, ORDER + 3);
    checkOutput("after_flush_reload", o_coef_ready, expectReload);
    checkOutput("after_flush_busy", o_busy, expectReload);
    if (expectReload) checkOutput("reload_addr0", o_tap_wr_addr, 0);
    primeModel = 0;
    hist.delete();
  endtask

  initial begin
    i_rst_n      = 1'b0;
    i_run        = 1'b1;
    i_load_req   = 1'b0;
    i_coef_valid = 1'b1;
    i_coef_data  = 16'h1234;
    i_smp_valid  = 1'b1;
    i_smp_data   = 16'h5678;

    #12;
    checkOutput("rst_busy", o_busy, 0);
    checkOutput("rst_smp_ready", o_smp_ready, 0);
    checkOutput("rst_coef_ready", o_coef_ready, 0);
    checkOutput("rst_fir_en", o_fir_en, 0);
    checkOutput("rst_out_valid", o_out_valid, 0);
    checkOutput("rst_wr_en", o_tap_wr_en, 0);
    checkOutput("rst_wr_addr", o_tap_wr_addr, 0);

    #5;
    i_rst_n      = 1'b1;
    i_coef_valid = 1'b0;
    i_smp_valid  = 1'b0;
    #1;
    checkOutput("pre_edge_idle", o_smp_ready, 0);
    tick();
    checkOutput("first_edge_run", o_smp_ready, 1);

    // Back-to-back samples: valid output appears after the third acceptance.
    applyStimulus(16'd1);
    applyStimulus(16'd2);
    applyStimulus(16'd3);
    applyStimulus(16'd4);
    idleSampleCycle();

    // Random coefficient load, then a flush with two merged reload requests.
    requestLoad();
    loadCoefs(1'b0);
    flushPhase(-1, -1, 1'b0);
    requestLoad();
    loadCoefs(1'b0);
    flushPhase(3, 30, 1'b1);
    loadCoefs(1'b1);
    flushPhase(-1, -1, 1'b0);

    // Unit impulse: output is the input two accepted samples back.
    applyStimulus(16'd100);
    applyStimulus(16'hFFF9);
    applyStimulus(16'd5);
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 1) == 1) applyStimulus(16'($urandom));
      else idleSampleCycle();
    end

    // Dropping run mid-stream keeps the prime count.
    i_run       = 1'b0;
    i_smp_valid = 1'b1;
    i_smp_data  = 16'h0BAD;
    #1;
    checkOutput("run_drop_ready", o_smp_ready, 0);
    checkOutput("run_drop_fir_en", o_fir_en, 0);
    checkOutput("idle_data_pass", o_fir_data_in, 16'h0BAD);
    tick();
    checkOutput("idle_busy", o_busy, 0);
    checkOutput("idle_out_valid", o_out_valid, 0);
    i_run = 1'b1;
    #1;
    checkOutput("idle_resume_ready", o_smp_ready, 0);
    tick();
    applyStimulus(16'h0042);
    applyStimulus(16'h0043);

    // Reset in the middle of a load abandons it.
    requestLoad();
    for (int i = 0; i < 20; i++) begin
      i_coef_valid = 1'b1;
      i_coef_data  = 16'($urandom);
      #1;
      checkOutput("partial_addr", o_tap_wr_addr, i);
      tick();
    end
    i_coef_valid = 1'b1;
    i_smp_valid  = 1'b1;
    #1;
    i_rst_n = 1'b0;
    #1;
    checkOutput("midload_rst_wr_en", o_tap_wr_en, 0);
    checkOutput("midload_rst_coef_ready", o_coef_ready, 0);
    checkOutput("midload_rst_busy", o_busy, 0);
    checkOutput("midload_rst_fir_en", o_fir_en, 0);
    checkOutput("midload_rst_smp_ready", o_smp_ready, 0);
    checkOutput("midload_rst_out_valid", o_out_valid, 0);
    checkOutput("midload_rst_addr", o_tap_wr_addr, 0);
    primeModel    = 0;
    impulseLoaded = 0;
    hist.delete();
    @(negedge i_clk);
    i_rst_n     = 1'b1;
    i_smp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("post_rst_run", o_smp_ready, 1);
      checkOutput("post_rst_no_wr", o_tap_wr_en, 0);
    end
    i_coef_valid = 1'b0;
    applyStimulus(16'd7);
    applyStimulus(16'd8);
    applyStimulus(16'd9);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
